// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and width helpers for the write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, OWN} arb_state_t;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: round-robin selector returning the first set req after ptr, wrapping through ptr last
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);
  localparam logic [2*N-1:0] ONE = 1;
  logic [2*N-1:0] masked;
  assign masked = {req, req} & ~((ONE << (int'(ptr) + 1)) - ONE);
  // lowest surviving bit of the doubled vector is the next holder in rotation order
  always_comb begin
    valid = |masked;
    idx = '0;
    for (int i = 2 * N - 1; i >= 0; i--)
      if (masked[i]) idx = PW'(i % N);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one syn_fifo write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 3,
  parameter int MAX_BURST = 4,
  localparam int IW = idx_w(NUM_REQ),
  localparam int BW = cnt_w(MAX_BURST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         wdata,
  input  logic                      ful_fg,
  output logic [IW-1:0]             owner,
  output logic                      busy
);
  arb_state_t state, state_n;
  logic [IW-1:0] owner_n, last, last_n, pidx;
  logic [BW-1:0] bcnt, bcnt_n;
  logic pvalid, own_req, acc, leave;
  rr_pick #(.N(NUM_REQ), .PW(IW)) u_pick (
    .req(req),
    .ptr(state == OWN ? owner : last),
    .valid(pvalid),
    .idx(pidx)
  );
  // beat acceptance and burst exit, decided on the same edge the full flag is seen
  always_comb begin
    own_req = req[owner];
    acc = !rst && state == OWN && own_req && !ful_fg;
    leave = state == OWN && (!own_req || (acc && bcnt == BW'(MAX_BURST - 1)));
  end
  // one-hot grant to the owner and its data slice onto the FIFO write port
  always_comb begin
    gnt = '0;
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc && owner == IW'(i)) begin
        gnt[i] = 1'b1;
        wdata = din[i*DATA_W +: DATA_W];
      end
  end
  assign wr_en = |gnt;
  assign busy = state == OWN;
  // next ownership: claim from idle, hand over on exit without a bubble, count beats
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n = last;
    bcnt_n = bcnt;
    if (state == IDLE) begin
      state_n = pvalid ? OWN : IDLE;
      owner_n = pvalid ? pidx : owner;
      bcnt_n = '0;
    end else if (leave) begin
      last_n = owner;
      bcnt_n = '0;
      state_n = pvalid ? OWN : IDLE;
      owner_n = pvalid ? pidx : owner;
    end else if (acc) begin
      bcnt_n = bcnt + BW'(1);
    end
  end
  // state register; last starts at the top index so producer 0 wins first
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last <= IW'(NUM_REQ - 1);
      bcnt <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last <= last_n;
      bcnt <= bcnt_n;
    end
  // grants stay exclusive and never write into a full FIFO
  always_ff @(posedge clk)
    if (!rst) begin
      assert ($onehot0(gnt));
      assert (!(wr_en && ful_fg));
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random checks of the arbiter against a depth-8 FIFO model
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 3, D = 8;
  logic clk = 0, rst = 1;
  logic [N-1:0] req, gnt, req_on = '0;
  logic [N*W-1:0] din;
  logic wr_en, ful_fg, busy, rd_en = 0, ful_force = 0;
  logic [W-1:0] wdata;
  logic [1:0] owner;
  logic [W-1:0] val [N];
  int sent [N];
  int lim [N];
  logic [W-1:0] mem_d [D];
  logic [1:0] mem_t [D];
  logic [W-1:0] rd_exp [N];
  int wp, rp, cnt;
  int checks = 0, errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .wr_en(wr_en),
    .wdata(wdata), .ful_fg(ful_fg), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_prod
    assign req[g] = req_on[g] && sent[g] < lim[g];
    assign din[g*W +: W] = val[g];
  end
  assign ful_fg = ful_force || cnt == D;

  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        val[i] <= '0;
        sent[i] <= 0;
      end
      wp <= 0;
      rp <= 0;
      cnt <= 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (gnt[i]) begin
          val[i] <= val[i] + 1'b1;
          sent[i] <= sent[i] + 1;
          mem_d[wp] <= wdata;
          mem_t[wp] <= 2'(i);
        end
      if (wr_en) wp <= (wp + 1) % D;
      if (rd_en && cnt > 0) rp <= (rp + 1) % D;
      cnt <= cnt + int'(wr_en) - int'(rd_en && cnt > 0);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input string tag, input int own, input logic [W-1:0] d);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_owner"}, owner, own);
    chk({tag, "_wr_en"}, wr_en, 1);
    chk({tag, "_gnt"}, gnt, 1 << own);
    chk({tag, "_wdata"}, wdata, d);
  endtask

  task automatic do_rst;
    rst = 1;
    req_on = '0;
    rd_en = 0;
    ful_force = 0;
    for (int i = 0; i < N; i++) lim[i] = 1 << 30;
    step;
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) lim[i] = 1 << 30;
    step;
    step;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner, 0);
    chk("rst_wdata", wdata, 0);
    // single producer, six beats: two bursts back to back
    rst = 0;
    req_on = 4'b0001;
    lim[0] = 6;
    #1;
    chk("t1_arb_busy", busy, 0);
    chk("t1_arb_wr_en", wr_en, 0);
    for (int k = 0; k < 6; k++) begin
      step;
      #1;
      beat("t1_beat", 0, W'(k));
    end
    step;
    #1;
    chk("t1_drop_wr_en", wr_en, 0);
    chk("t1_drop_busy", busy, 1);
    step;
    #1;
    chk("t1_idle_busy", busy, 0);
    // all four producers, reads keep the FIFO from filling
    do_rst;
    req_on = 4'hF;
    rd_en = 1;
    #1;
    chk("t2_arb_wr_en", wr_en, 0);
    for (int k = 0; k < 17; k++) begin
      step;
      #1;
      beat("t2_rr", (k / 4) % 4, W'((k / 16) * 4 + k % 4));
    end
    // FIFO fills after eight beats, one read frees exactly one slot
    do_rst;
    req_on = 4'b0001;
    lim[0] = 10;
    for (int k = 0; k < 8; k++) begin
      step;
      #1;
      beat("t3_fill", 0, W'(k));
    end
    for (int k = 0; k < 2; k++) begin
      step;
      #1;
      chk("t3_full_flag", ful_fg, 1);
      chk("t3_full_wr_en", wr_en, 0);
      chk("t3_full_gnt", gnt, 0);
      chk("t3_full_busy", busy, 1);
      chk("t3_full_owner", owner, 0);
    end
    rd_en = 1;
    #1;
    chk("t3_rd_wr_en", wr_en, 0);
    step;
    rd_en = 0;
    #1;
    chk("t3_room_flag", ful_fg, 0);
    beat("t3_one_more", 0, 3'd0);
    step;
    #1;
    chk("t3_refull_flag", ful_fg, 1);
    chk("t3_refull_wr_en", wr_en, 0);
    step;
    #1;
    chk("t3_still_wr_en", wr_en, 0);
    // owner 2 drops after two beats; next holder by rotation from 2
    for (int v = 0; v < 2; v++) begin
      do_rst;
      req_on = 4'b0100;
      lim[2] = 2;
      step;
      #1;
      beat("t4_b0", 2, 3'd0);
      req_on = v == 0 ? 4'b0110 : 4'b1110;
      step;
      #1;
      beat("t4_b1", 2, 3'd1);
      step;
      #1;
      chk("t4_drop_wr_en", wr_en, 0);
      chk("t4_drop_gnt", gnt, 0);
      chk("t4_drop_owner", owner, 2);
      step;
      #1;
      beat("t4_next", v == 0 ? 1 : 3, 3'd0);
    end
    // reset mid-burst forces outputs low and restarts arbitration from producer 0
    do_rst;
    req_on = 4'b0010;
    step;
    #1;
    beat("t5_b0", 1, 3'd0);
    step;
    #1;
    beat("t5_b1", 1, 3'd1);
    rst = 1;
    req_on = 4'b0011;
    #1;
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_wr_en", wr_en, 0);
    chk("t5_rst_wdata", wdata, 0);
    step;
    rst = 0;
    #1;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_wr_en", wr_en, 0);
    step;
    #1;
    beat("t5_first", 0, 3'd0);
    // random traffic with per-producer ordering scoreboard on the FIFO output
    do_rst;
    for (int i = 0; i < N; i++) rd_exp[i] = '0;
    for (int c = 0; c < 2000; c++) begin
      req_on = 4'($urandom);
      ful_force = $urandom_range(0, 3) == 0;
      rd_en = 1'($urandom_range(0, 1));
      #1;
      chk("t6_onehot", $onehot0(gnt), 1);
      chk("t6_wr_full", wr_en && ful_fg, 0);
      chk("t6_wr_en", wr_en, |gnt);
      for (int i = 0; i < N; i++)
        if (gnt[i]) begin
          chk("t6_req", req[i], 1);
          chk("t6_owner", owner, i);
          chk("t6_wdata", wdata, val[i]);
        end
      if (!wr_en) chk("t6_wdata0", wdata, 0);
      if (rd_en && cnt > 0) begin
        chk("t6_order", mem_d[rp], rd_exp[mem_t[rp]]);
        rd_exp[mem_t[rp]] = rd_exp[mem_t[rp]] + 1'b1;
      end
      step;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
